eth_tx_arbiter: RTL

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

---
 rtl/eth_pkg.sv | 25 ++
 rtl/eth_rr_pick.sv | 32 +++
 rtl/eth_tx_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared types and defaults for the Ethernet transmit arbiter.
// Holds the FSM encoding, arbitration modes and timing defaults.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XMIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int IFG_DEF       = 12;
  localparam int START_TO_DEF  = 64;
  localparam int MAX_FRAME_DEF = 1600;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational winner select: rotating search from ptr+1,
// or plain lowest-index-first when fixed_i is set.
module eth_rr_pick #(
  parameter int N_CH = 3,
  parameter int IW   = 2
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic            fixed_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  int c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int k = 0; k < N_CH; k++) begin
      c = fixed_i ? k : (int'(ptr_i) + 1 + k) % N_CH;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// GMII transmit arbiter: grants one source per frame, forwards its
// stream one cycle late, enforces start/overrun timeouts and the IFG.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int N_CH          = 3,
  parameter int DW            = 8,
  parameter int ARB_MODE      = ARB_RR,
  parameter int IFG_CYCLES    = IFG_DEF,
  parameter int START_TIMEOUT = START_TO_DEF,
  parameter int MAX_FRAME     = MAX_FRAME_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_req,
  output logic [N_CH-1:0]          ch_gnt,
  input  logic [N_CH-1:0]          ch_tx_en,
  input  logic [N_CH*DW-1:0]       ch_txd,
  output logic                     gmii_tx_en,
  output logic [DW-1:0]            gmii_txd,
  output logic [$clog2(N_CH)-1:0]  gnt_id,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int IW = $clog2(N_CH);
  localparam int CW =
    $clog2(max3(IFG_CYCLES, START_TIMEOUT, MAX_FRAME) + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0] gnt_q, gnt_d, win;
  logic [IW-1:0]   gid_q, gid_d, ptr_q, ptr_d, win_idx;
  logic            win_any, en_q, en_d, err_q, err_d, sel_en;
  logic [DW-1:0]   txd_q, txd_d, sel_d;

  eth_rr_pick #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_pick (
    .req_i   (ch_req),
    .ptr_i   (ptr_q),
    .fixed_i (ARB_MODE == ARB_FIXED),
    .gnt_o   (win),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  assign sel_en = ch_tx_en[gid_q];
  assign sel_d  = ch_txd[int'(gid_q)*DW +: DW];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    gnt_d   = gnt_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    en_d    = 1'b0;
    txd_d   = '0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (win_any) begin
          state_d = ST_GRANT;
          gnt_d   = win;
          gid_d   = win_idx;
          ptr_d   = win_idx;
        end
      end
      ST_GRANT: begin
        if (sel_en) begin
          state_d = ST_XMIT;
          cnt_d   = '0;
          en_d    = 1'b1;
          txd_d   = sel_d;
        end else if (!ch_req[gid_q] ||
                     cnt_q == CW'(START_TIMEOUT-1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          gnt_d   = '0;
          err_d   = ch_req[gid_q];
        end
      end
      ST_XMIT: begin
        // cnt counts XMIT cycles; the first enabled cycle was in GRANT
        if (!sel_en || cnt_q == CW'(MAX_FRAME-1)) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          gnt_d   = '0;
          err_d   = sel_en;
        end else begin
          en_d  = 1'b1;
          txd_d = sel_d;
        end
      end
      ST_GAP: begin
        if (cnt_q == CW'(IFG_CYCLES-1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      gid_q   <= '0;
      ptr_q   <= IW'(N_CH-1);
      en_q    <= 1'b0;
      txd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      en_q    <= en_d;
      txd_q   <= txd_d;
      err_q   <= err_d;
    end
  end

  assign ch_gnt      = gnt_q;
  assign gmii_tx_en  = en_q;
  assign gmii_txd    = txd_q;
  assign gnt_id      = gid_q;
  assign busy        = (state_q != eth_pkg::ST_IDLE);
  assign err_timeout = err_q;

endmodule
